reg_file_mp: RTL and testbench

REG_FILE_MP -- requirements
Module: reg_file_mp

---
 rtl/reg_file_pkg.sv | 21 ++
 rtl/reg_file_bypass_mux.sv | 33 +++
 rtl/reg_file_mp.sv | 139 +++++++++++++
 tb/tb_reg_file_mp.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared defaults, clear-FSM state type and address-width helper for the
// multi-ported register file.
package reg_file_pkg;

   localparam int DEF_WIDTH       = 128;
   localparam int DEF_DEPTH       = 128;
   localparam int DEF_NUM_RD      = 6;
   localparam int DEF_NUM_WR      = 2;
   localparam int DEF_CLR_PER_CYC = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_t;

   // Address bits needed to index 'depth' entries (never less than one bit).
   function automatic int addr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/reg_file_bypass_mux.sv
// Per-read-port select between the stored array word and any same-cycle
// write data aimed at the same address. Later write ports override earlier
// ones, so the highest-indexed matching port is forwarded.
module reg_file_bypass_mux
   import reg_file_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int AW     = 7,
   parameter int NUM_WR = DEF_NUM_WR
) (
   input  logic [AW-1:0]           rd_addr,
   input  logic [WIDTH-1:0]        arr_data,
   input  logic [NUM_WR-1:0]       wr_en,
   input  logic [NUM_WR*AW-1:0]    wr_addr,
   input  logic [NUM_WR*WIDTH-1:0] wr_data,
   input  logic                    blank,
   output logic [WIDTH-1:0]        rd_data
);

   // Forward the highest-indexed matching write; blank forces zero during a clear.
   always_comb begin
      rd_data = arr_data;
      for (int p = 0; p < NUM_WR; p++) begin
         if (wr_en[p] && (wr_addr[p*AW +: AW] == rd_addr)) begin
            rd_data = wr_data[p*WIDTH +: WIDTH];
         end
      end
      if (blank) begin
         rd_data = '0;
      end
   end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-ported register file with write-to-read bypass, same-address write
// conflict flag and a block-wise clear sweep that also runs after reset.
module reg_file_mp
   import reg_file_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int DEPTH       = DEF_DEPTH,
   parameter int NUM_RD      = DEF_NUM_RD,
   parameter int NUM_WR      = DEF_NUM_WR,
   parameter int CLR_PER_CYC = DEF_CLR_PER_CYC,
   localparam int AW         = addr_w(DEPTH)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_RD*AW-1:0]    rd_addr,
   output logic [NUM_RD*WIDTH-1:0] rd_data,
   input  logic [NUM_WR-1:0]       wr_en,
   input  logic [NUM_WR*AW-1:0]    wr_addr,
   input  logic [NUM_WR*WIDTH-1:0] wr_data,
   input  logic                    init_req,
   output logic                    init_busy,
   output logic                    wr_conflict
);

   localparam int NBLK = DEPTH / CLR_PER_CYC;
   localparam int CW   = (NBLK > 1) ? $clog2(NBLK) : 1;

   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("reg_file_mp: DEPTH must be a power of two and at least 2");
   end
   if ((CLR_PER_CYC < 1) || ((DEPTH % CLR_PER_CYC) != 0)) begin : g_bad_clr
      $error("reg_file_mp: CLR_PER_CYC must divide DEPTH");
   end

   clr_state_t       state, state_nxt;
   logic [CW-1:0]    clr_idx, clr_idx_nxt;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    blk_base;
   logic             clearing;
   logic             conflict;

   assign clearing  = (state == CLEAR);
   assign init_busy = clearing;
   // CLR_PER_CYC divides a power of two, so this product never overflows AW
   // for any legal clr_idx; the cast only matters when a single block spans
   // the whole array, where clr_idx is always 0.
   assign blk_base  = AW'(clr_idx) * AW'(CLR_PER_CYC);

   // Clear FSM state and block counter; reset starts a fresh sweep.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= CLEAR;
         clr_idx <= '0;
      end else begin
         state   <= state_nxt;
         clr_idx <= clr_idx_nxt;
      end
   end

   // Next-state: enter CLEAR on request, step blocks, leave after the last one.
   always_comb begin
      state_nxt   = state;
      clr_idx_nxt = clr_idx;
      case (state)
         IDLE: begin
            if (init_req) begin
               state_nxt   = CLEAR;
               clr_idx_nxt = '0;
            end
         end
         CLEAR: begin
            if (clr_idx == CW'(NBLK - 1)) begin
               state_nxt   = IDLE;
               clr_idx_nxt = '0;
            end else begin
               clr_idx_nxt = clr_idx + 1'b1;
            end
         end
         default: begin
            state_nxt   = CLEAR;
            clr_idx_nxt = '0;
         end
      endcase
   end

   // Detect any pair of enabled write ports aimed at the same address.
   always_comb begin
      conflict = 1'b0;
      for (int p = 0; p < NUM_WR; p++) begin
         for (int q = p + 1; q < NUM_WR; q++) begin
            if (wr_en[p] && wr_en[q] && (wr_addr[p*AW +: AW] == wr_addr[q*AW +: AW])) begin
               conflict = 1'b1;
            end
         end
      end
   end

   // Conflict pulse; suppressed when the next cycle will be part of a clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_conflict <= 1'b0;
      end else begin
         wr_conflict <= conflict && (state == IDLE) && !init_req;
      end
   end

   // Array update: zero one block per clear cycle, otherwise commit writes
   // in port order so the highest-indexed port lands last.
   always_ff @(posedge clk) begin
      if (clearing) begin
         for (int i = 0; i < CLR_PER_CYC; i++) begin
            mem[blk_base + AW'(i)] <= '0;
         end
      end else begin
         for (int p = 0; p < NUM_WR; p++) begin
            if (wr_en[p]) begin
               mem[wr_addr[p*AW +: AW]] <= wr_data[p*WIDTH +: WIDTH];
            end
         end
      end
   end

   for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
      reg_file_bypass_mux #(
         .WIDTH  (WIDTH),
         .AW     (AW),
         .NUM_WR (NUM_WR)
      ) u_mux (
         .rd_addr  (rd_addr[r*AW +: AW]),
         .arr_data (mem[rd_addr[r*AW +: AW]]),
         .wr_en    (wr_en),
         .wr_addr  (wr_addr),
         .wr_data  (wr_data),
         .blank    (clearing),
         .rd_data  (rd_data[r*WIDTH +: WIDTH])
      );
   end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: a default-parameter instance and a small
// WIDTH=32/DEPTH=16/NUM_RD=3/NUM_WR=4/CLR_PER_CYC=4 instance share clk/reset.
module tb_reg_file_mp;

   logic clk;
   logic reset;

   // default instance: AW=7, WIDTH=128, 6 read, 2 write
   logic [6*7-1:0]   rd_addr1;
   logic [6*128-1:0] rd_data1;
   logic [1:0]       wr_en1;
   logic [2*7-1:0]   wr_addr1;
   logic [2*128-1:0] wr_data1;
   logic             init_req1, busy1, conf1;

   // small instance: AW=4, WIDTH=32, 3 read, 4 write
   logic [3*4-1:0]   rd_addr2;
   logic [3*32-1:0]  rd_data2;
   logic [3:0]       wr_en2;
   logic [4*4-1:0]   wr_addr2;
   logic [4*32-1:0]  wr_data2;
   logic             init_req2, busy2, conf2;

   int n_cmp = 0;
   int n_bad = 0;

   localparam logic [127:0] PAT_A = {32{4'hA}};

   reg_file_mp dut1 (
      .clk(clk), .reset(reset), .rd_addr(rd_addr1), .rd_data(rd_data1),
      .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
      .init_req(init_req1), .init_busy(busy1), .wr_conflict(conf1)
   );

   reg_file_mp #(.WIDTH(32), .DEPTH(16), .NUM_RD(3), .NUM_WR(4), .CLR_PER_CYC(4)) dut2 (
      .clk(clk), .reset(reset), .rd_addr(rd_addr2), .rd_data(rd_data2),
      .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
      .init_req(init_req2), .init_busy(busy2), .wr_conflict(conf2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      int c1, c2;
      #1;
      n_cmp++; if (busy1 !== 1'b1) begin n_bad++; $display("FAIL rst_busy1: got %b want 1", busy1); end
      n_cmp++; if (busy2 !== 1'b1) begin n_bad++; $display("FAIL rst_busy2: got %b want 1", busy2); end
      n_cmp++; if (conf1 !== 1'b0) begin n_bad++; $display("FAIL rst_conf1: got %b want 0", conf1); end
      n_cmp++; if (conf2 !== 1'b0) begin n_bad++; $display("FAIL rst_conf2: got %b want 0", conf2); end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      c1 = 0; c2 = 0;
      for (int k = 0; k < 100 && (busy1 || busy2); k++) begin
         c1 += int'(busy1);
         c2 += int'(busy2);
         @(negedge clk);
      end
      n_cmp++; if (c1 != 16) begin n_bad++; $display("FAIL rst_busy_cycles1: got %0d want 16", c1); end
      n_cmp++; if (c2 != 4)  begin n_bad++; $display("FAIL rst_busy_cycles2: got %0d want 4", c2); end
      for (int b = 0; b < 128; b += 6) begin
         for (int r = 0; r < 6; r++) rd_addr1[r*7 +: 7] = 7'((b + r) % 128);
         #1;
         for (int r = 0; r < 6; r++) begin
            n_cmp++;
            if (rd_data1[r*128 +: 128] !== '0) begin
               n_bad++; $display("FAIL rst_zero1 r%0d: got %h want 0", (b + r) % 128, rd_data1[r*128 +: 128]);
            end
         end
         @(negedge clk);
      end
      for (int b = 0; b < 16; b += 3) begin
         for (int r = 0; r < 3; r++) rd_addr2[r*4 +: 4] = 4'((b + r) % 16);
         #1;
         for (int r = 0; r < 3; r++) begin
            n_cmp++;
            if (rd_data2[r*32 +: 32] !== '0) begin
               n_bad++; $display("FAIL rst_zero2 r%0d: got %h want 0", (b + r) % 16, rd_data2[r*32 +: 32]);
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_bypass();
      @(negedge clk);
      wr_en1 = 2'b01; wr_addr1[0 +: 7] = 7'd5; wr_data1[0 +: 128] = PAT_A;
      rd_addr1 = '0; rd_addr1[0 +: 7] = 7'd5; rd_addr1[21 +: 7] = 7'd5; rd_addr1[7 +: 7] = 7'd6;
      #1;
      n_cmp++; if (rd_data1[0 +: 128] !== PAT_A)   begin n_bad++; $display("FAIL byp_rd0: got %h want %h", rd_data1[0 +: 128], PAT_A); end
      n_cmp++; if (rd_data1[384 +: 128] !== PAT_A) begin n_bad++; $display("FAIL byp_rd3: got %h want %h", rd_data1[384 +: 128], PAT_A); end
      n_cmp++; if (rd_data1[128 +: 128] !== '0)    begin n_bad++; $display("FAIL byp_rd1_nomatch: got %h want 0", rd_data1[128 +: 128]); end
      @(negedge clk);
      wr_en1 = 2'b00;
      #1;
      n_cmp++; if (rd_data1[0 +: 128] !== PAT_A)   begin n_bad++; $display("FAIL byp_stored0: got %h want %h", rd_data1[0 +: 128], PAT_A); end
      n_cmp++; if (rd_data1[384 +: 128] !== PAT_A) begin n_bad++; $display("FAIL byp_stored3: got %h want %h", rd_data1[384 +: 128], PAT_A); end
   endtask

   task automatic test_conflict();
      @(negedge clk);
      wr_en1 = 2'b11; wr_addr1 = {7'd9, 7'd9}; wr_data1 = {128'd2, 128'd1};
      rd_addr1[14 +: 7] = 7'd9;
      #1;
      n_cmp++; if (rd_data1[256 +: 128] !== 128'd2) begin n_bad++; $display("FAIL cfl_bypass: got %h want 2", rd_data1[256 +: 128]); end
      n_cmp++; if (conf1 !== 1'b0) begin n_bad++; $display("FAIL cfl_same_cycle: got %b want 0", conf1); end
      @(negedge clk);
      wr_en1 = 2'b11; wr_addr1 = {7'd11, 7'd10}; wr_data1 = {128'h0B, 128'h0A};
      #1;
      n_cmp++; if (rd_data1[256 +: 128] !== 128'd2) begin n_bad++; $display("FAIL cfl_stored: got %h want 2", rd_data1[256 +: 128]); end
      n_cmp++; if (conf1 !== 1'b1) begin n_bad++; $display("FAIL cfl_pulse: got %b want 1", conf1); end
      @(negedge clk);
      wr_en1 = 2'b00;
      rd_addr1[0 +: 7] = 7'd10; rd_addr1[7 +: 7] = 7'd11;
      #1;
      n_cmp++; if (conf1 !== 1'b0) begin n_bad++; $display("FAIL cfl_one_cycle: got %b want 0", conf1); end
      n_cmp++; if (rd_data1[0 +: 128] !== 128'h0A)   begin n_bad++; $display("FAIL cfl_r10: got %h want 0a", rd_data1[0 +: 128]); end
      n_cmp++; if (rd_data1[128 +: 128] !== 128'h0B) begin n_bad++; $display("FAIL cfl_r11: got %h want 0b", rd_data1[128 +: 128]); end
   endtask

   task automatic test_init_req();
      int cnt;
      @(negedge clk);
      wr_en1 = 2'b01; wr_addr1[0 +: 7] = 7'd3; wr_data1[0 +: 128] = 128'd7; init_req1 = 1'b1;
      rd_addr1[0 +: 7] = 7'd3; rd_addr1[7 +: 7] = 7'd5; rd_addr1[14 +: 7] = 7'd9;
      #1;
      n_cmp++; if (rd_data1[0 +: 128] !== 128'd7) begin n_bad++; $display("FAIL init_bypass: got %h want 7", rd_data1[0 +: 128]); end
      n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL init_idle_busy: got %b want 0", busy1); end
      @(negedge clk);
      init_req1 = 1'b0;
      wr_en1 = 2'b11; wr_addr1 = {7'd3, 7'd3}; wr_data1 = {128'h66, 128'h55};
      cnt = 0;
      for (int k = 0; k < 100 && busy1; k++) begin
         #1;
         for (int r = 0; r < 3; r++) begin
            n_cmp++;
            if (rd_data1[r*128 +: 128] !== '0) begin
               n_bad++; $display("FAIL init_rd_zero port%0d cyc%0d: got %h want 0", r, cnt, rd_data1[r*128 +: 128]);
            end
         end
         n_cmp++; if (conf1 !== 1'b0) begin n_bad++; $display("FAIL init_conf cyc%0d: got %b want 0", cnt, conf1); end
         init_req1 = (cnt == 5);
         cnt++;
         @(negedge clk);
      end
      init_req1 = 1'b0; wr_en1 = 2'b00;
      n_cmp++; if (cnt != 16) begin n_bad++; $display("FAIL init_busy_cycles: got %0d want 16", cnt); end
      #1;
      n_cmp++; if (rd_data1[0 +: 128] !== '0)   begin n_bad++; $display("FAIL init_r3: got %h want 0", rd_data1[0 +: 128]); end
      n_cmp++; if (rd_data1[128 +: 128] !== '0) begin n_bad++; $display("FAIL init_r5: got %h want 0", rd_data1[128 +: 128]); end
      n_cmp++; if (rd_data1[256 +: 128] !== '0) begin n_bad++; $display("FAIL init_r9: got %h want 0", rd_data1[256 +: 128]); end
      n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL init_done: got %b want 0", busy1); end
   endtask

   task automatic test_reset_mid();
      int c1, c2;
      @(negedge clk);
      wr_en1 = 2'b11; wr_addr1 = {7'd7, 7'd7}; wr_data1 = {128'h1234, 128'h1111};
      @(negedge clk);
      wr_en1 = 2'b00; rd_addr1[0 +: 7] = 7'd7;
      #1;
      n_cmp++; if (conf1 !== 1'b1) begin n_bad++; $display("FAIL mid_conf_before: got %b want 1", conf1); end
      n_cmp++; if (rd_data1[0 +: 128] !== 128'h1234) begin n_bad++; $display("FAIL mid_r7_prio: got %h want 1234", rd_data1[0 +: 128]); end
      #1 reset = 1'b1;
      #1;
      n_cmp++; if (conf1 !== 1'b0) begin n_bad++; $display("FAIL mid_conf_reset: got %b want 0", conf1); end
      n_cmp++; if (busy1 !== 1'b1) begin n_bad++; $display("FAIL mid_busy_reset: got %b want 1", busy1); end
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 100 && (busy1 || busy2); k++) @(negedge clk);
      #1;
      n_cmp++; if (rd_data1[0 +: 128] !== '0) begin n_bad++; $display("FAIL mid_r7_swept: got %h want 0", rd_data1[0 +: 128]); end
      @(negedge clk);
      wr_en1 = 2'b01; wr_addr1[0 +: 7] = 7'd7; wr_data1[0 +: 128] = 128'hBEEF;
      @(negedge clk);
      wr_en1 = 2'b00; init_req1 = 1'b1;
      @(negedge clk);
      init_req1 = 1'b0;
      repeat (10) @(negedge clk);
      n_cmp++; if (busy1 !== 1'b1) begin n_bad++; $display("FAIL mid_busy_cyc10: got %b want 1", busy1); end
      #2 reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      c1 = 0; c2 = 0;
      for (int k = 0; k < 100 && (busy1 || busy2); k++) begin
         c1 += int'(busy1);
         c2 += int'(busy2);
         @(negedge clk);
      end
      n_cmp++; if (c1 != 16) begin n_bad++; $display("FAIL mid_restart_cycles1: got %0d want 16", c1); end
      n_cmp++; if (c2 != 4)  begin n_bad++; $display("FAIL mid_restart_cycles2: got %0d want 4", c2); end
   endtask

   task automatic test_sweep();
      int cnt;
      @(negedge clk);
      wr_en2 = 4'hF; wr_addr2 = {4{4'd2}}; wr_data2 = {32'h44, 32'h33, 32'h22, 32'h11};
      rd_addr2 = '0; rd_addr2[0 +: 4] = 4'd2; rd_addr2[4 +: 4] = 4'd2;
      #1;
      n_cmp++; if (rd_data2[0 +: 32] !== 32'h44)  begin n_bad++; $display("FAIL sw_byp0: got %h want 44", rd_data2[0 +: 32]); end
      n_cmp++; if (rd_data2[32 +: 32] !== 32'h44) begin n_bad++; $display("FAIL sw_byp1: got %h want 44", rd_data2[32 +: 32]); end
      @(negedge clk);
      wr_en2 = 4'b0111; wr_addr2 = {4{4'd4}}; wr_data2 = {32'h88, 32'h77, 32'h66, 32'h55};
      rd_addr2[0 +: 4] = 4'd4; rd_addr2[8 +: 4] = 4'd2;
      #1;
      n_cmp++; if (rd_data2[0 +: 32] !== 32'h77)  begin n_bad++; $display("FAIL sw_byp_p2: got %h want 77", rd_data2[0 +: 32]); end
      n_cmp++; if (rd_data2[64 +: 32] !== 32'h44) begin n_bad++; $display("FAIL sw_stored_p3: got %h want 44", rd_data2[64 +: 32]); end
      n_cmp++; if (conf2 !== 1'b1) begin n_bad++; $display("FAIL sw_conf_a: got %b want 1", conf2); end
      @(negedge clk);
      wr_en2 = 4'b0000;
      #1;
      n_cmp++; if (rd_data2[0 +: 32] !== 32'h77) begin n_bad++; $display("FAIL sw_stored_p2: got %h want 77", rd_data2[0 +: 32]); end
      n_cmp++; if (conf2 !== 1'b1) begin n_bad++; $display("FAIL sw_conf_b: got %b want 1", conf2); end
      @(negedge clk);
      init_req2 = 1'b1;
      #1;
      n_cmp++; if (conf2 !== 1'b0) begin n_bad++; $display("FAIL sw_conf_end: got %b want 0", conf2); end
      @(negedge clk);
      init_req2 = 1'b0;
      cnt = 0;
      for (int k = 0; k < 100 && busy2; k++) begin
         cnt++;
         @(negedge clk);
      end
      n_cmp++; if (cnt != 4) begin n_bad++; $display("FAIL sw_clear_cycles: got %0d want 4", cnt); end
      #1;
      n_cmp++; if (rd_data2[0 +: 32] !== '0)  begin n_bad++; $display("FAIL sw_r4_zero: got %h want 0", rd_data2[0 +: 32]); end
      n_cmp++; if (rd_data2[64 +: 32] !== '0) begin n_bad++; $display("FAIL sw_r2_zero: got %h want 0", rd_data2[64 +: 32]); end
   endtask

   initial begin
      reset = 1'b1;
      rd_addr1 = '0; wr_en1 = '0; wr_addr1 = '0; wr_data1 = '0; init_req1 = 1'b0;
      rd_addr2 = '0; wr_en2 = '0; wr_addr2 = '0; wr_data2 = '0; init_req2 = 1'b0;
      test_reset();
      test_bypass();
      test_conflict();
      test_init_req();
      test_reset_mid();
      test_sweep();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
